// File: rtl/seg_scan_multi.sv
// Multi-channel seven-segment countdown driver: one shared shift-add-3 engine
// converts each channel in turn; a registered output stage applies lamp test, blink, overflow and blanking.
module seg_scan_multi #(
    parameter int CHANNELS  = 2,
    parameter int DIGITS    = 2,
    parameter int WIDTH     = 8,
    parameter int BLINK_DIV = 50
) (
    input  logic                         clk_divide,
    input  logic                         rst_n,
    input  logic                         enable,
    input  logic [CHANNELS*WIDTH-1:0]    data,
    input  logic                         lzb,
    input  logic [CHANNELS-1:0]          blink_mask,
    output logic [CHANNELS*DIGITS*7-1:0] seg,
    output logic                         frame_done
);

    localparam int          BW      = DIGITS * 4;
    localparam int          CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int          CNT_W   = $clog2(WIDTH + 1);
    localparam int          BL_W    = $clog2(BLINK_DIV);
    localparam logic [31:0] MAX_VAL = 32'(10**DIGITS - 1);
    localparam logic [6:0]  BLANK   = 7'b1111111;
    localparam logic [6:0]  DASH    = 7'b1111110;

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, WRITE} state_t;

    state_t            state, state_nx;
    logic [CH_W-1:0]   ch;
    logic [WIDTH-1:0]  bin_sr;
    logic [BW-1:0]     bcd_w, bcd_adj;
    logic              ovf_w;
    logic [CNT_W-1:0]  cnt;
    logic [BW-1:0]     store_bcd [CHANNELS];
    logic [CHANNELS-1:0] store_ovf;
    logic [BL_W-1:0]   blink_cnt;
    logic              phase;
    logic [WIDTH-1:0]  cur_val;
    logic [CHANNELS*DIGITS*7-1:0] seg_nx;
    logic              lead;
    logic [3:0]        nib;
    logic [6:0]        code;

    function automatic logic [BW-1:0] bcd_adjust(input logic [BW-1:0] b);
        logic [BW-1:0] r;
        r = b;
        for (int i = 0; i < DIGITS; i++)
            if (b[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = b[i*4 +: 4] + 4'd3;
        return r;
    endfunction

    function automatic logic [6:0] seg_code(input logic [3:0] n);
        case (n)
            4'd0:    seg_code = 7'b0000001;
            4'd1:    seg_code = 7'b1001111;
            4'd2:    seg_code = 7'b0010010;
            4'd3:    seg_code = 7'b0000110;
            4'd4:    seg_code = 7'b1001100;
            4'd5:    seg_code = 7'b0100100;
            4'd6:    seg_code = 7'b0100000;
            4'd7:    seg_code = 7'b0001111;
            4'd8:    seg_code = 7'b0000000;
            4'd9:    seg_code = 7'b0000100;
            default: seg_code = BLANK;
        endcase
    endfunction

    assign cur_val = data[ch*WIDTH +: WIDTH];
    assign bcd_adj = bcd_adjust(bcd_w);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = LOAD;
            LOAD:    state_nx = SHIFT;
            SHIFT:   if (cnt == CNT_W'(1)) state_nx = WRITE;
            WRITE:   state_nx = LOAD;
            default: state_nx = IDLE;
        endcase
    end

    // Conversion engine: load, WIDTH shift-add-3 steps, write back to the channel store
    always_ff @(posedge clk_divide or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ch         <= '0;
            bin_sr     <= '0;
            bcd_w      <= '0;
            ovf_w      <= 1'b0;
            cnt        <= '0;
            store_ovf  <= '0;
            frame_done <= 1'b0;
            for (int k = 0; k < CHANNELS; k++) store_bcd[k] <= '0;
        end else begin
            state      <= state_nx;
            frame_done <= (state == WRITE) && (ch == CH_W'(CHANNELS - 1));
            case (state)
                LOAD: begin
                    bin_sr <= cur_val;
                    bcd_w  <= '0;
                    ovf_w  <= 32'(cur_val) > MAX_VAL;
                    cnt    <= CNT_W'(WIDTH);
                end
                SHIFT: begin
                    {bcd_w, bin_sr} <= {bcd_adj[BW-2:0], bin_sr, 1'b0};
                    cnt             <= cnt - 1'b1;
                end
                WRITE: begin
                    store_bcd[ch] <= bcd_w;
                    store_ovf[ch] <= ovf_w;
                    if (ch == CH_W'(CHANNELS - 1)) ch <= '0;
                    else                           ch <= ch + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Free-running blink timebase, independent of enable
    always_ff @(posedge clk_divide or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt <= '0;
            phase     <= 1'b0;
        end else if (blink_cnt == BL_W'(BLINK_DIV - 1)) begin
            blink_cnt <= '0;
            phase     <= ~phase;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    // Display decode: lamp test > blink > overflow > leading-zero blanking > digit
    always_comb begin
        seg_nx = '1;
        lead   = 1'b0;
        nib    = '0;
        code   = BLANK;
        for (int k = 0; k < CHANNELS; k++) begin
            lead = lzb;
            for (int d = DIGITS - 1; d >= 0; d--) begin
                nib = store_bcd[k][d*4 +: 4];
                if (nib != 4'd0 || d == 0) lead = 1'b0;
                if (!enable)                     code = 7'b0000000;
                else if (blink_mask[k] && phase) code = BLANK;
                else if (store_ovf[k])           code = DASH;
                else if (lead)                   code = BLANK;
                else                             code = seg_code(nib);
                seg_nx[(k*DIGITS+d)*7 +: 7] = code;
            end
        end
    end

    always_ff @(posedge clk_divide or negedge rst_n) begin
        if (!rst_n) seg <= '1;
        else        seg <= seg_nx;
    end

endmodule

// File: tb/tb_seg_scan_multi.sv
// Bench for seg_scan_multi: decimal reference model checked against the
// displayed digits, plus frame timing, lamp test, blink and async reset.
module tb_seg_scan_multi;

    localparam int CHANNELS  = 2;
    localparam int DIGITS    = 2;
    localparam int WIDTH     = 8;
    localparam int BLINK_DIV = 4;

    logic                         clk_divide = 1'b0;
    logic                         rst_n      = 1'b0;
    logic                         enable     = 1'b1;
    logic                         lzb        = 1'b0;
    logic [CHANNELS*WIDTH-1:0]    data       = '0;
    logic [CHANNELS-1:0]          blink_mask = '0;
    logic [CHANNELS*DIGITS*7-1:0] seg;
    logic                         frame_done;

    int total = 0;
    int bad   = 0;
    int edges = 0;
    int n;

    seg_scan_multi #(
        .CHANNELS(CHANNELS), .DIGITS(DIGITS), .WIDTH(WIDTH), .BLINK_DIV(BLINK_DIV)
    ) dut (
        .clk_divide(clk_divide), .rst_n(rst_n), .enable(enable), .data(data),
        .lzb(lzb), .blink_mask(blink_mask), .seg(seg), .frame_done(frame_done)
    );

    always #5 clk_divide = ~clk_divide;

    always @(posedge clk_divide or negedge rst_n)
        if (!rst_n) edges <= 0;
        else        edges <= edges + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] seg_of(input int v);
        case (v)
            0: return 7'b0000001;  1: return 7'b1001111;
            2: return 7'b0010010;  3: return 7'b0000110;
            4: return 7'b1001100;  5: return 7'b0100100;
            6: return 7'b0100000;  7: return 7'b0001111;
            8: return 7'b0000000;  9: return 7'b0000100;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [6:0] exp_digit(input int v, input int d, input logic l,
                                             input logic en, input logic bl);
        int p   = 10**d;
        int lim = 10**DIGITS - 1;
        if (!en)                  return 7'b0000000;
        if (bl)                   return 7'b1111111;
        if (v > lim)              return 7'b1111110;
        if (l && d > 0 && v < p)  return 7'b1111111;
        return seg_of((v / p) % 10);
    endfunction

    // Assumes inputs held for at least one edge and data held for a full frame
    task automatic check_now(input string tag);
        logic ph;
        int   v;
        ph = (((edges - 1) / BLINK_DIV) % 2) == 1;
        for (int k = 0; k < CHANNELS; k++) begin
            v = int'(data[k*WIDTH +: WIDTH]);
            for (int d = 0; d < DIGITS; d++)
                chk($sformatf("%s_c%0d_d%0d", tag, k, d), 32'(seg[(k*DIGITS+d)*7 +: 7]),
                    32'(exp_digit(v, d, lzb, enable, blink_mask[k] && ph)));
        end
    endtask

    task automatic wait_fd(output int cycles);
        cycles = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_divide);
            cycles++;
            if (frame_done === 1'b1) return;
        end
        chk("fd_timeout", 32'd0, 32'd1);
    endtask

    task automatic settle(input string tag);
        int c;
        wait_fd(c);
        wait_fd(c);
        @(negedge clk_divide);
        check_now(tag);
    endtask

    initial begin
        // Reset and first frame
        data = {8'd30, 8'd7};
        repeat (3) @(negedge clk_divide);
        chk("rst_seg", 32'(seg), 32'({(CHANNELS*DIGITS*7){1'b1}}));
        chk("rst_fd", 32'(frame_done), 32'd0);
        rst_n = 1'b1;
        wait_fd(n);
        chk("first_fd_lat", n, 21);
        @(negedge clk_divide);
        chk("c0d1", 32'(seg[13:7]),  32'(7'b0000001));
        chk("c0d0", 32'(seg[6:0]),   32'(7'b0001111));
        chk("c1d1", 32'(seg[27:21]), 32'(7'b0000110));
        chk("c1d0", 32'(seg[20:14]), 32'(7'b0000001));
        check_now("f1");

        // Directed values: blanking, zero, overflow boundary
        data = {8'd30, 8'd5};   lzb = 1'b1; settle("lzb5");
        data = {8'd30, 8'd0};   lzb = 1'b1; settle("lzb0");
        data = {8'd99, 8'd100}; lzb = 1'b0; settle("ovf100");
        data = {8'd100, 8'd99}; lzb = 1'b1; settle("ovf99");
        data = {8'd0, 8'd255};  lzb = 1'b1; settle("max");
        chk("ovf_dash", 32'(seg[6:0]), 32'(7'b1111110));

        // Random values
        for (int r = 0; r < 10; r++) begin
            data = {8'($urandom_range(0, 255)), 8'($urandom_range(0, 130))};
            lzb  = 1'($urandom_range(0, 1));
            settle($sformatf("rnd%0d", r));
        end

        // Lamp test across a frame, frame period unchanged
        data = {8'd42, 8'd8}; lzb = 1'b1;
        settle("pre_lamp");
        wait_fd(n);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_divide);
            n++;
            if (n >= 6 && n <= 9) check_now($sformatf("lamp%0d", n));
            if (n == 5) enable = 1'b0;
            if (n == 8) enable = 1'b1;
            if (frame_done === 1'b1) break;
        end
        chk("fd_period", n, 20);

        // Blink on channel 1 only
        blink_mask = 2'b10;
        @(negedge clk_divide);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk_divide);
            check_now($sformatf("blink%0d", i));
        end
        blink_mask = 2'b00;
        @(negedge clk_divide);

        // Asynchronous reset during channel 1 shifting
        wait_fd(n);
        repeat (15) @(negedge clk_divide);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_seg", 32'(seg), 32'({(CHANNELS*DIGITS*7){1'b1}}));
        chk("mid_rst_fd", 32'(frame_done), 32'd0);
        data = {8'd61, 8'd17}; lzb = 1'b0;
        @(negedge clk_divide);
        rst_n = 1'b1;
        wait_fd(n);
        chk("post_rst_fd_lat", n, 21);
        @(negedge clk_divide);
        check_now("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
